// File: rtl/spi_reg_peripheral_pkg.sv
// Shared constants, frame layout and FSM encoding for the SPI register peripheral.
package spi_reg_pkg;
   localparam int FRAME_BITS = 16;
   localparam int ADDR_BITS  = 7;
   localparam int DATA_BITS  = 8;
   localparam int CNT_BITS   = 5;

   localparam int ADDR_EN_OUT_LO = 0;
   localparam int ADDR_EN_OUT_HI = 1;
   localparam int ADDR_EN_PWM_LO = 2;
   localparam int ADDR_EN_PWM_HI = 3;
   localparam int ADDR_DUTY      = 4;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

   typedef struct packed {
      logic                 wr;
      logic [ADDR_BITS-1:0] addr;
      logic [DATA_BITS-1:0] data;
   } frame_t;
endpackage

// File: rtl/spi_reg_peripheral_if.sv
// SPI pins in, decoded register values out; master = external controller side.
interface spi_reg_if;
   logic       sclk;
   logic       copi;
   logic       ncs;
   logic [7:0] en_reg_out_7_0;
   logic [7:0] en_reg_out_15_8;
   logic [7:0] en_reg_pwm_7_0;
   logic [7:0] en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;

   modport master (
      output sclk, copi, ncs,
      input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
   );
   modport slave (
      input  sclk, copi, ncs,
      output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
   );
endinterface

// File: rtl/spi_reg_peripheral_sync_edge.sv
// N-flop synchronizer plus one edge-detect flop; rise/fall are single-cycle pulses.
module sync_edge #(
   parameter int   STAGES   = 2,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   // [STAGES-1:0] synchronizer chain, [STAGES] previous synchronized level
   logic [STAGES:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= {(STAGES+1){IDLE_LVL}};
      else     sync_q <= {sync_q[STAGES-1:0], d_i};
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  =  sync_q[STAGES-1] & ~sync_q[STAGES];
   assign fall_o  = ~sync_q[STAGES-1] &  sync_q[STAGES];
endmodule

// File: rtl/spi_reg_peripheral.sv
// Write-only SPI mode-0 slave decoding 16-bit frames into a small register bank.
module spi_reg_peripheral
   import spi_reg_pkg::*;
#(
   parameter int NUM_REGS    = 5,
   parameter int SYNC_STAGES = 2
) (
   input logic      clk,
   input logic      rst,
   spi_reg_if.slave bus
);
   logic ncs_s, ncs_rise, ncs_fall;
   logic sclk_rise, sclk_lvl_unused, sclk_fall_unused;
   logic copi_s, copi_rise_unused, copi_fall_unused;

   sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_ncs (
      .clk(clk), .rst(rst), .d_i(bus.ncs),
      .level_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sclk (
      .clk(clk), .rst(rst), .d_i(bus.sclk),
      .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
   );
   sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_copi (
      .clk(clk), .rst(rst), .d_i(bus.copi),
      .level_o(copi_s), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused)
   );

   state_e                state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   logic                  wr_en;
   frame_t                frame;
   logic [DATA_BITS-1:0]  regs_q [NUM_REGS];

   assign frame = frame_t'(shift_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ncs_fall) begin
               state_d = SHIFT;
               shift_d = '0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            // a chip-select release beats a coincident sclk edge
            if (ncs_rise) begin
               state_d = COMMIT;
            end else if (sclk_rise && !ncs_s) begin
               shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
         end
         COMMIT: begin
            wr_en = (cnt_q == CNT_BITS'(FRAME_BITS)) && frame.wr
                    && (int'(frame.addr) < NUM_REGS);
            // back-to-back frames: a start seen here is not lost
            if (ncs_fall) begin
               state_d = SHIFT;
               shift_d = '0;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_REGS; i++)
            if (int'(frame.addr) == i) regs_q[i] <= frame.data;
      end
   end

   assign bus.en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
   assign bus.en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
   assign bus.en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
   assign bus.en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
   assign bus.pwm_duty_cycle  = regs_q[ADDR_DUTY];
endmodule

// File: doc/spi_reg_peripheral.md
# spi_reg_peripheral

Write-only SPI Mode-0 peripheral that sits directly upstream of the PWM/output stage inside `tt_um_uwasic_onboarding_bernice_lam`. It receives 16-bit frames on `ui_in[2:0]` (SCLK, COPI, nCS) from an external controller, which is asynchronous to `clk`, and decodes each frame into a five-entry register bank. The registers drive the output-enable, PWM-enable and duty-cycle inputs of the PWM generator.

## Interface
- `FRAME_BITS`, 16: bits per valid transaction.
- `NUM_REGS`, 5: implemented register count; addresses `0x00`..`NUM_REGS-1`.
- `SYNC_STAGES`, 2: synchronizer flops per SPI input, not counting the edge-detect flop.

Ports:
- `clk` input 1: system clock, 10 MHz nominal.
- `rst` input 1: asynchronous, active-high reset.
- `sclk` input 1: SPI clock, asynchronous to `clk`.
- `copi` input 1: SPI data in, MSB first.
- `ncs` input 1: SPI chip select, active-low.
- `en_reg_out_7_0` output 8: register `0x00`.
- `en_reg_out_15_8` output 8: register `0x01`.
- `en_reg_pwm_7_0` output 8: register `0x02`.
- `en_reg_pwm_15_8` output 8: register `0x03`.
- `pwm_duty_cycle` output 8: register `0x04`.

## Operation
- **Frame format**, MSB first:
  - bit 15: R/W̄ (1 = write).
  - bits 14:8: 7-bit address.
  - bits 7:0: data.
- **Input conditioning:** `sclk`, `copi` and `ncs` each pass through `SYNC_STAGES` flops plus one edge-detect flop. All decoding uses the synchronized signals only.
- **States:**
  - IDLE: `ncs_s` high.
    - On an `ncs_s` falling edge: go to SHIFT, clear `bit_cnt` (5 bits) and `shift` (16 bits).
  - SHIFT: on each synchronized `sclk` rising edge while `ncs_s` is low:
    - `shift <= {shift[14:0], copi_s}`.
    - `bit_cnt` increments and saturates at 31.
    - Falling `sclk` edges are ignored.
    - On an `ncs_s` rising edge: go to COMMIT.
  - COMMIT: lasts one cycle, then returns to IDLE. The write is applied only if all of the following hold:
    - `bit_cnt == FRAME_BITS`
    - `shift[15] == 1`
    - `shift[14:8] < NUM_REGS`
  - If the conditions hold, `reg[shift[14:8]] <= shift[7:0]`. Otherwise nothing changes: short frames, long frames, read frames and out-of-range addresses are silently dropped.
- **Reads:** no MISO; read frames have no effect.
- **Register bank:** holds its value between writes. Only the addressed register changes.
- **Reset:** `rst` high clears all five registers, the synchronizers, `shift` and `bit_cnt`, and forces IDLE, asynchronously. This includes reset mid-frame. After `rst` falls, the block waits for a fresh `ncs_s` falling edge. If `ncs` is already low at release, the partial frame is never committed.
- **Start during COMMIT:** an `ncs_s` falling edge seen during the COMMIT cycle starts a new frame on the next cycle. Back-to-back frames are not lost.

## Timing
- All outputs reset to `0x00`.
- **Latency:** the register output changes on the 4th `clk` rising edge after the raw `ncs` rising edge: 2 sync edges, 1 edge-detect edge, 1 COMMIT edge. Setup is assumed met at the first sync flop.
- **SCLK limits:**
  - SCLK high and low phases must each be ≥ 3 `clk` periods, so SCLK ≤ `clk`/6 (1 MHz used in test).
  - The `ncs` fall to first SCLK rise must be ≥ 3 `clk` periods.
  - The last SCLK fall to `ncs` rise must be ≥ 3 `clk` periods.
- **Simultaneous edges:** if an `ncs_s` rising edge and an `sclk_s` rising edge are detected in the same cycle, the `ncs` edge wins and the `sclk` edge is not counted.
- **Glitch filtering:** none beyond synchronization. Pulses shorter than 1 `clk` period may be missed.

## Structure
- **Package `spi_reg_pkg`:**
  - address constants `ADDR_EN_OUT_LO`=0, `ADDR_EN_OUT_HI`=1, `ADDR_EN_PWM_LO`=2, `ADDR_EN_PWM_HI`=3, `ADDR_DUTY`=4.
  - `FRAME_BITS`, `ADDR_BITS`=7, `DATA_BITS`=8.
  - State enum `{IDLE, SHIFT, COMMIT}`.
- **Sub-module `sync_edge`:** an N-flop synchronizer with `rise`/`fall` pulse outputs and an async active-high reset to a parameterized idle level (1 for `ncs`, 0 for `sclk`/`copi`). It is instantiated three times.
- **Top body:** the frame FSM, the shift register, the bit counter and the register bank.

## Test plan
- **Reset values:** assert `rst` for 5 cycles → all five outputs read `0x00`. Release `rst` → outputs stay `0x00` with the SPI pins idle.
- **Single write:** write addr `0x00`, data `0xF0` (frame `0x80F0`) at 1 MHz SCLK → `en_reg_out_7_0 == 0xF0` exactly 4 `clk` edges after `ncs` rises; the other registers stay `0x00`.
- **Full sweep:** write `0x01=0xCC`, `0x02=0x55`, `0x03=0x0F`, `0x04=0x80` back-to-back with 3-cycle `ncs` gaps → all values present and register `0x00` unchanged.
- **Rejected frames:**
  - read frame `0x00AA`
  - address `0x05` (`0x85AA`)
  - 15-bit frame
  - 17-bit frame

  → no register changes.
- **Reset mid-frame:** pulse `rst` after 8 SCLK bits of `0x8455`, then finish clocking the frame → `pwm_duty_cycle` stays `0x00`. A following full `0x8455` frame sets it to `0x55`.
- **Overwrite:** write `0x04=0x80`, then `0x04=0xFF` → output shows `0x80`, then `0xFF`, with no intermediate value.
